// File: rtl/ocimem_access_arbiter.sv
// ocimem_access_arbiter: shares the single-port OCI debug RAM between JTAG strobes and the CPU debug slave,
// with fair alternation under contention and read data returned to MonDReg or cpu_readdata.
module ocimem_access_arbiter #(
   parameter int ADDR_W    = 8,
   parameter int JADDR_LSB = 17
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [37:0]       jdo,
   input  logic              take_action_ocimem_a,
   input  logic              take_action_ocimem_b,
   input  logic              take_no_action_ocimem_a,
   output logic [31:0]       MonDReg,
   output logic              monitor_ready,
   output logic              jtag_overrun,
   input  logic [ADDR_W-1:0] cpu_address,
   input  logic              cpu_read,
   input  logic              cpu_write,
   input  logic [31:0]       cpu_writedata,
   output logic              cpu_waitrequest,
   output logic [31:0]       cpu_readdata,
   output logic              cpu_readdatavalid,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_wren,
   output logic [31:0]       ram_wdata,
   input  logic [31:0]       ram_rdata
);
   typedef enum logic [2:0] {S_IDLE, S_JACC, S_CACC, S_RDW, S_RET} state_t;
   state_t              r_state;
   logic [ADDR_W-1:0]   r_ptr;
   logic [ADDR_W-1:0]   r_jaddr;
   logic [31:0]         r_jdata;
   logic                r_jpend;
   logic                r_jwr;
   logic                r_jflight;
   logic                r_gnt_j;
   logic                r_op_wr;
   logic                r_last_j;
   logic [31:0]         r_mon;
   logic                r_ovr;
   logic [31:0]         r_crdata;
   logic                r_crvalid;
   logic                r_wait;
   logic [ADDR_W-1:0]   w_jaddr_ld;
   logic [ADDR_W-1:0]   w_base;
   logic                w_busy;
   logic                w_op;
   logic                w_cap;
   logic                w_ovr_set;
   logic                w_creq;
   logic                w_gnt_j;
   logic                w_unused;
   assign w_jaddr_ld = jdo[JADDR_LSB +: ADDR_W];
   // an address load in the same cycle as an op strobe redirects that op
   assign w_base     = take_action_ocimem_a ? w_jaddr_ld : r_ptr;
   assign w_busy     = r_jpend | r_jflight;
   assign w_op       = take_action_ocimem_b | take_no_action_ocimem_a;
   assign w_cap      = w_op & ~w_busy;
   assign w_ovr_set  = (w_op & w_busy) | (take_action_ocimem_b & take_no_action_ocimem_a);
   assign w_creq     = cpu_read | cpu_write;
   assign w_gnt_j    = r_jpend & (~w_creq | ~r_last_j);
   assign w_unused   = ^{jdo[37:35], jdo[2:0]};
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= S_IDLE;
         r_ptr     <= '0;
         r_jaddr   <= '0;
         r_jdata   <= '0;
         r_jpend   <= 1'b0;
         r_jwr     <= 1'b0;
         r_jflight <= 1'b0;
         r_gnt_j   <= 1'b0;
         r_op_wr   <= 1'b0;
         r_last_j  <= 1'b0;
         r_mon     <= '0;
         r_ovr     <= 1'b0;
         r_crdata  <= '0;
         r_crvalid <= 1'b0;
         r_wait    <= 1'b1;
      end else begin
         if (take_action_ocimem_a)
            r_ptr <= w_jaddr_ld;
         if (w_cap) begin
            r_ptr   <= w_base + ADDR_W'(1);
            r_jaddr <= w_base;
            r_jwr   <= take_action_ocimem_b;
            r_jdata <= jdo[34:3];
            r_jpend <= 1'b1;
         end
         r_ovr     <= (r_ovr & ~take_action_ocimem_a) | w_ovr_set;
         r_crvalid <= 1'b0;
         r_wait    <= 1'b1;
         case (r_state)
            S_IDLE:
               if (r_jpend | w_creq) begin
                  r_gnt_j   <= w_gnt_j;
                  r_last_j  <= w_gnt_j;
                  r_op_wr   <= w_gnt_j ? r_jwr : cpu_write;
                  r_jflight <= w_gnt_j;
                  r_wait    <= w_gnt_j;
                  r_state   <= w_gnt_j ? S_JACC : S_CACC;
               end
            S_JACC: begin
               r_jpend <= 1'b0;
               if (r_op_wr)
                  r_jflight <= 1'b0;
               r_state <= r_op_wr ? S_IDLE : S_RDW;
            end
            S_CACC:
               r_state <= r_op_wr ? S_IDLE : S_RDW;
            S_RDW: begin
               if (r_gnt_j) begin
                  r_mon     <= ram_rdata;
                  r_jflight <= 1'b0;
               end else
                  r_crdata <= ram_rdata;
               r_crvalid <= ~r_gnt_j;
               r_state   <= S_RET;
            end
            default:
               r_state <= S_IDLE;
         endcase
      end
   end
   assign ram_wren          = ((r_state == S_JACC) | (r_state == S_CACC)) & r_op_wr;
   assign ram_addr          = (r_state == S_JACC) ? r_jaddr : (r_state == S_CACC) ? cpu_address : '0;
   assign ram_wdata         = (r_state == S_JACC) ? r_jdata : (r_state == S_CACC) ? cpu_writedata : '0;
   assign MonDReg           = r_mon;
   assign monitor_ready     = ~w_busy;
   assign jtag_overrun      = r_ovr;
   assign cpu_waitrequest   = r_wait;
   assign cpu_readdata      = r_crdata;
   assign cpu_readdatavalid = r_crvalid;
endmodule
